// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// =============================================================================
// Module   : alu_op_sequencer_if
// Brief    : Command and response ready/valid bundle for alu_op_sequencer.
// Revision : 1.0 - initial release
// =============================================================================
interface alu_op_sequencer_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [ADDRESS_WIDTH-1:0] cmd_opcode;
  logic [DATA_WIDTH-1:0]    cmd_a;
  logic [DATA_WIDTH-1:0]    cmd_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [DATA_WIDTH-1:0]    rsp_data;
  logic                     rsp_carry;

  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_carry
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_carry
  );
endinterface
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : alu_op_sequencer
// Brief    : Command front-end for the dual-memory/ALU datapath; optional
//            SEQ_OPCOUNT_EN macro adds op_count / ptr_wrapped outputs.
// Revision : 1.0 - initial release
// =============================================================================
module alu_op_sequencer #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDRESS_WIDTH  = 4,
  parameter int RESULT_LATENCY = 2
) (
  input  wire                      clk,
  input  wire                      reset_n,
  alu_op_sequencer_if.slave        bus,
  output logic                     cs0,
  output logic                     cs1,
  output logic                     mem_en0,
  output logic                     mem_en1,
  output logic [ADDRESS_WIDTH-1:0] addr0,
  output logic [ADDRESS_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0]    a_out,
  output logic [DATA_WIDTH-1:0]    b_out,
  output logic [ADDRESS_WIDTH-1:0] opcode_out,
  input  wire  [DATA_WIDTH-1:0]    result_in,
  input  wire                      carry_in
`ifdef SEQ_OPCOUNT_EN
  ,
  output logic [15:0]              op_count,
  output logic [0:0]               ptr_wrapped
`endif
);

  localparam logic [3:0] c_latency = 4'(RESULT_LATENCY);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic                     w_accept;
  logic                     w_capture;
  logic                     w_rsp_done;

  logic                     r_cmd_ready;
  logic                     r_cs;
  logic                     r_mem_en;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_a_out;
  logic [DATA_WIDTH-1:0]    r_b_out;
  logic [ADDRESS_WIDTH-1:0] r_opcode;
  logic [ADDRESS_WIDTH-1:0] r_opcode_out;
  logic [ADDRESS_WIDTH-1:0] r_wr_ptr;
  logic [3:0]               r_wait_cnt;
  logic                     r_rsp_valid;
  logic [DATA_WIDTH-1:0]    r_rsp_data;
  logic                     r_rsp_carry;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_rsp_done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.cmd_valid && r_cmd_ready) begin
          w_accept     = 1'b1;
          w_state_next = ST_WRITE;
        end
      end
      ST_WRITE: w_state_next = ST_READ;
      ST_READ:  w_state_next = ST_WAIT;
      ST_WAIT: begin
        // Counter holds the number of WAIT cycles left including this one.
        if (r_wait_cnt == 4'd1) begin
          w_capture    = 1'b1;
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (r_rsp_valid && bus.rsp_ready) begin
          w_rsp_done   = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd_ready  <= 1'b1;
      r_cs         <= 1'b0;
      r_mem_en     <= 1'b0;
      r_addr       <= '0;
      r_a_out      <= '0;
      r_b_out      <= '0;
      r_opcode     <= '0;
      r_opcode_out <= '0;
      r_wr_ptr     <= '0;
      r_wait_cnt   <= 4'd0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_carry  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_cmd_ready <= 1'b0;
            r_opcode    <= bus.cmd_opcode;
            r_cs        <= 1'b1;
            r_mem_en    <= 1'b1;
            r_addr      <= r_wr_ptr;
            r_a_out     <= bus.cmd_a;
            r_b_out     <= bus.cmd_b;
          end
        end
        ST_WRITE: begin
          r_mem_en     <= 1'b0;
          r_opcode_out <= r_opcode;
        end
        ST_READ: begin
          r_cs       <= 1'b0;
          r_wait_cnt <= c_latency;
        end
        ST_WAIT: begin
          r_wait_cnt <= r_wait_cnt - 4'd1;
          if (w_capture) begin
            r_rsp_data  <= result_in;
            r_rsp_carry <= carry_in;
            r_rsp_valid <= 1'b1;
          end
        end
        ST_RESP: begin
          if (w_rsp_done) begin
            r_rsp_valid <= 1'b0;
            r_wr_ptr    <= r_wr_ptr + ADDRESS_WIDTH'(1);
            r_cmd_ready <= 1'b1;
          end
        end
        default: r_cmd_ready <= 1'b1;
      endcase
    end
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_carry = r_rsp_carry;
  assign cs0           = r_cs;
  assign cs1           = r_cs;
  assign mem_en0       = r_mem_en;
  assign mem_en1       = r_mem_en;
  assign addr0         = r_addr;
  assign addr1         = r_addr;
  assign a_out         = r_a_out;
  assign b_out         = r_b_out;
  assign opcode_out    = r_opcode_out;

`ifdef SEQ_OPCOUNT_EN
  logic [15:0] r_op_count;
  logic        r_ptr_wrapped;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op_count    <= 16'd0;
      r_ptr_wrapped <= 1'b0;
    end else if (w_rsp_done) begin
      r_op_count <= r_op_count + 16'd1;
      if (r_wr_ptr == {ADDRESS_WIDTH{1'b1}}) r_ptr_wrapped <= 1'b1;
    end
  end

  assign op_count    = r_op_count;
  assign ptr_wrapped = r_ptr_wrapped;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : tb_alu_op_sequencer
// Brief    : Self-checking bench: vector table, reset corner cases, random run.
// Revision : 1.0 - initial release
// =============================================================================
module tb_alu_op_sequencer;

  localparam int RL = 2;

  logic       clk;
  logic       reset_n;
  logic       cs0, cs1, mem_en0, mem_en1;
  logic [3:0] addr0, addr1, opcode_out;
  logic [7:0] a_out, b_out;
  logic [7:0] result_in;
  logic       carry_in;
`ifdef SEQ_OPCOUNT_EN
  logic [15:0] op_count;
  logic [0:0]  ptr_wrapped;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int n_since_reset = 0;

  alu_op_sequencer_if #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4)) bus ();

  alu_op_sequencer #(
    .DATA_WIDTH(8), .ADDRESS_WIDTH(4), .RESULT_LATENCY(RL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .cs0(cs0), .cs1(cs1), .mem_en0(mem_en0), .mem_en1(mem_en1),
    .addr0(addr0), .addr1(addr1), .a_out(a_out), .b_out(b_out),
    .opcode_out(opcode_out), .result_in(result_in), .carry_in(carry_in)
`ifdef SEQ_OPCOUNT_EN
    , .op_count(op_count), .ptr_wrapped(ptr_wrapped)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Stand-in datapath: {carry, result} for a few opcodes.
  function automatic logic [8:0] alu_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'h1:    return {1'b0, a} + {1'b0, b};
      4'h2:    return {1'b0, a} - {1'b0, b};
      4'h3:    return {1'b0, a & b};
      4'h4:    return {1'b0, a ^ b};
      default: return {1'b0, a};
    endcase
  endfunction

  // Called at a negedge in IDLE; returns at the negedge of the following IDLE cycle.
  task automatic run_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [8:0] drive, input logic [8:0] expect_rsp,
                         input int stall, input bit hold);
    int         waited;
    logic [3:0] ea;
    waited = 0;
    bus.cmd_valid  = 1'b1;
    bus.cmd_opcode = op;
    bus.cmd_a      = a;
    bus.cmd_b      = b;
    while (bus.cmd_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (bus.cmd_ready !== 1'b1) begin
      check("accept_timeout", 64'(bus.cmd_ready), 64'd1);
      bus.cmd_valid = 1'b0;
      return;
    end
    ea = 4'(n_since_reset % 16);
    result_in = ~drive[7:0];
    carry_in  = ~drive[8];

    @(negedge clk);
    if (hold) begin
      bus.cmd_opcode = 4'($urandom);
      bus.cmd_a      = 8'($urandom);
      bus.cmd_b      = 8'($urandom);
    end else begin
      bus.cmd_valid = 1'b0;
    end
    check("write_phase",
          64'({cs0, cs1, mem_en0, mem_en1, addr0, addr1, a_out, b_out, bus.cmd_ready, bus.rsp_valid}),
          64'({4'b1111, ea, ea, a, b, 2'b00}));

    @(negedge clk);
    check("read_phase",
          64'({cs0, cs1, mem_en0, mem_en1, addr0, addr1, opcode_out, bus.cmd_ready, bus.rsp_valid}),
          64'({4'b1100, ea, ea, op, 2'b00}));

    for (int k = 1; k <= RL; k++) begin
      @(negedge clk);
      check("wait_phase",
            64'({cs0, cs1, mem_en0, mem_en1, bus.cmd_ready, bus.rsp_valid, opcode_out}),
            64'({6'b000000, op}));
      if (k == RL) begin
        result_in = drive[7:0];
        carry_in  = drive[8];
      end
    end
    bus.rsp_ready = (stall == 0);

    @(negedge clk);
    result_in = ~drive[7:0];
    carry_in  = ~drive[8];
    check("rsp_first",
          64'({bus.rsp_valid, bus.rsp_carry, bus.rsp_data, bus.cmd_ready, cs0, mem_en0}),
          64'({1'b1, expect_rsp, 3'b000}));
    for (int s = 1; s <= stall; s++) begin
      @(negedge clk);
      check("rsp_hold",
            64'({bus.rsp_valid, bus.rsp_carry, bus.rsp_data, bus.cmd_ready}),
            64'({1'b1, expect_rsp, 1'b0}));
      if (s == stall) bus.rsp_ready = 1'b1;
    end

    @(negedge clk);
    bus.rsp_ready = 1'b0;
    n_since_reset++;
    check("back_to_idle",
          64'({bus.rsp_valid, bus.cmd_ready, cs0, mem_en0}),
          64'(4'b0100));
`ifdef SEQ_OPCOUNT_EN
    check("op_count", 64'(op_count), 64'(n_since_reset % 65536));
    check("ptr_wrapped", 64'(ptr_wrapped), 64'(n_since_reset >= 16));
`endif
  endtask

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    int         stall;
    logic [7:0] exp_data;
    logic       exp_carry;
  } vec_t;

  vec_t       vecs[6];
  logic [3:0] t_op;
  logic [7:0] t_a, t_b;
  logic [8:0] t_r;
  int         seen;

  initial begin
    vecs[0] = '{op: 4'h1, a: 8'h05, b: 8'h03, stall: 0, exp_data: 8'h08, exp_carry: 1'b0};
    vecs[1] = '{op: 4'h1, a: 8'h10, b: 8'h20, stall: 6, exp_data: 8'h30, exp_carry: 1'b0};
    vecs[2] = '{op: 4'h1, a: 8'hFF, b: 8'h01, stall: 0, exp_data: 8'h00, exp_carry: 1'b1};
    vecs[3] = '{op: 4'h2, a: 8'h03, b: 8'h05, stall: 1, exp_data: 8'hFE, exp_carry: 1'b1};
    vecs[4] = '{op: 4'h3, a: 8'hF0, b: 8'h3C, stall: 0, exp_data: 8'h30, exp_carry: 1'b0};
    vecs[5] = '{op: 4'h4, a: 8'hAA, b: 8'h55, stall: 2, exp_data: 8'hFF, exp_carry: 1'b0};

    reset_n        = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_opcode = 4'h0;
    bus.cmd_a      = 8'h00;
    bus.cmd_b      = 8'h00;
    bus.rsp_ready  = 1'b0;
    result_in      = 8'h00;
    carry_in       = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_values",
          64'({cs0, cs1, mem_en0, mem_en1, addr0, addr1, a_out, b_out, opcode_out,
               bus.rsp_valid, bus.rsp_data, bus.rsp_carry, bus.cmd_ready}),
          64'd1);
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, alu_model(vecs[i].op, vecs[i].a, vecs[i].b),
              {vecs[i].exp_carry, vecs[i].exp_data}, vecs[i].stall, 1'b0);
    end

    // Reset asserted mid-WAIT: the in-flight command must vanish.
    bus.cmd_valid  = 1'b1;
    bus.cmd_opcode = 4'h1;
    bus.cmd_a      = 8'hFF;
    bus.cmd_b      = 8'h01;
    result_in      = 8'h00;
    carry_in       = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset",
          64'({cs0, cs1, mem_en0, mem_en1, addr0, addr1, a_out, b_out, opcode_out,
               bus.rsp_valid, bus.rsp_data, bus.rsp_carry, bus.cmd_ready}),
          64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    n_since_reset = 0;
    bus.rsp_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) seen++;
    end
    bus.rsp_ready = 1'b0;
    check("no_rsp_after_reset", 64'(seen), 64'd0);
    check("ready_after_reset", 64'(bus.cmd_ready), 64'd1);

    // 17 back-to-back commands with cmd_valid held: addresses 0..15 then 0.
    for (int i = 0; i < 17; i++) begin
      t_op = 4'($urandom_range(0, 15));
      t_a  = 8'($urandom);
      t_b  = 8'($urandom);
      t_r  = alu_model(t_op, t_a, t_b);
      run_cmd(t_op, t_a, t_b, t_r, t_r, 0, 1'b1);
    end

    for (int i = 0; i < 20; i++) begin
      t_op = 4'($urandom_range(0, 15));
      t_a  = 8'($urandom);
      t_b  = 8'($urandom);
      t_r  = alu_model(t_op, t_a, t_b);
      run_cmd(t_op, t_a, t_b, t_r, t_r, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    bus.cmd_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
